// File: rtl/itcm_loader.sv
// UART boot loader: receives a framed, checksummed image over a serial line and
// writes it word by word into the ITCM while holding the core in reset.
module itcm_loader #(
  parameter int unsigned CLKS_PER_BIT = 1128,
  parameter int unsigned MAX_WORDS    = 1024,
  parameter int unsigned TIMEOUT_CLKS = 1300000
) (
  input  logic        clk,
  input  logic        cpu_rst,
  input  logic        uart_rx,
  output logic        itcm_we,
  output logic [11:0] itcm_addr,
  output logic [31:0] itcm_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned IDX_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned ADDR_W = 12;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK} state_t;

  logic [1:0]       r_sync;
  logic             r_rx_prev;
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_rx_byte, w_rx_byte_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_rx_ferr, w_rx_ferr_nxt;
  logic             w_rx;
  logic             w_rx_busy;

  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [1:0]        r_bcnt, w_bcnt_nxt;
  logic [31:0]       r_word, w_word_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              w_abort;
  logic [LEN_W-1:0]  w_n;

  assign w_rx      = r_sync[1];
  assign w_rx_busy = (r_rx_state != RX_IDLE);

  // Byte receiver: start-bit glitch rejection, centre sampling, framing check
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_cnt_nxt      = r_cnt + CNT_W'(1);
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_rx_byte_nxt  = r_rx_byte;
    w_rx_valid_nxt = 1'b0;
    w_rx_ferr_nxt  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rx_prev && !w_rx) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          w_cnt_nxt      = '0;
          w_bit_nxt      = '0;
          w_rx_state_nxt = w_rx ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt      = '0;
          w_rx_state_nxt = RX_IDLE;
          if (w_rx) begin
            w_rx_valid_nxt = 1'b1;
            w_rx_byte_nxt  = r_shift;
          end else begin
            w_rx_ferr_nxt  = 1'b1;
          end
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign w_n = {r_rx_byte, r_len[7:0]};

  // Frame parser: sync, length, data words, checksum
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_bcnt_nxt  = r_bcnt;
    w_word_nxt  = r_word;
    w_csum_nxt  = r_csum;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_hold_nxt  = r_hold;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_abort     = 1'b0;
    w_tmo_nxt   = (r_state == S_IDLE || r_rx_valid || w_rx_busy) ? '0 : r_tmo + TMO_W'(1);
    if (r_state != S_IDLE && r_rx_ferr) begin
      w_abort = 1'b1;
    end else if (r_rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (r_rx_byte == 8'hA5) begin
            w_state_nxt = S_LEN_LO;
            w_hold_nxt  = 1'b1;
            w_idx_nxt   = '0;
            w_bcnt_nxt  = '0;
            w_csum_nxt  = '0;
          end
        end
        S_LEN_LO: begin
          w_len_nxt   = {8'h00, r_rx_byte};
          w_state_nxt = S_LEN_HI;
        end
        S_LEN_HI: begin
          w_len_nxt = w_n;
          if (w_n >= LEN_W'(1) && w_n <= LEN_W'(MAX_WORDS)) w_state_nxt = S_DATA;
          else w_abort = 1'b1;
        end
        S_DATA: begin
          w_word_nxt[{r_bcnt, 3'b000} +: 8] = r_rx_byte;
          w_csum_nxt = r_csum + r_rx_byte;
          w_bcnt_nxt = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = ADDR_W'({r_idx, 2'b00});
            w_wdata_nxt = {r_rx_byte, r_word[23:0]};
            w_idx_nxt   = r_idx + IDX_W'(1);
            if (LEN_W'(r_idx + IDX_W'(1)) == r_len) w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_rx_byte == r_csum) begin
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_abort = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && !w_rx_busy && r_tmo == TMO_W'(TIMEOUT_CLKS - 1)) begin
      w_abort = 1'b1;
    end
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
      w_hold_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_bcnt     <= '0;
      r_word     <= '0;
      r_csum     <= '0;
      r_tmo      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], uart_rx};
      r_rx_prev  <= w_rx;
      r_rx_state <= w_rx_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_byte  <= w_rx_byte_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_ferr  <= w_rx_ferr_nxt;
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_word     <= w_word_nxt;
      r_csum     <= w_csum_nxt;
      r_tmo      <= w_tmo_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_hold     <= w_hold_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign itcm_we    = r_we;
  assign itcm_addr  = r_addr;
  assign itcm_wdata = r_wdata;
  assign core_hold  = r_hold;
  assign load_done  = r_done;
  assign load_error = r_err;

endmodule

// File: tb/tb_itcm_loader.sv
// Bench for itcm_loader: drives UART frames and checks ITCM writes against a
// scoreboard of expected (address, data) pairs plus done/error pulse counts.
module tb_itcm_loader;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        itcm_we;
  logic [11:0] itcm_addr;
  logic [31:0] itcm_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;
  int d0;
  int e0;
  logic prev_hold = 1'b0;
  logic [11:0] exp_addr[$];
  logic [31:0] exp_data[$];

  always #5 clk = ~clk;

  itcm_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS(1024),
    .TIMEOUT_CLKS(2000)
  ) dut (
    .clk(clk),
    .cpu_rst(cpu_rst),
    .uart_rx(uart_rx),
    .itcm_we(itcm_we),
    .itcm_addr(itcm_addr),
    .itcm_wdata(itcm_wdata),
    .core_hold(core_hold),
    .load_done(load_done),
    .load_error(load_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop_bit;
    idle(CPB);
    uart_rx = 1'b1;
    idle(4);
  endtask

  // First byte sent is the most significant of the n used bytes
  task automatic send_vec(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic expect_wr(input logic [11:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"}, 32'(itcm_we), 32'd0);
    chk({tag, "_addr"}, 32'(itcm_addr), 32'd0);
    chk({tag, "_wdata"}, itcm_wdata, 32'd0);
    chk({tag, "_hold"}, 32'(core_hold), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_error), 32'd0);
  endtask

  // Output monitor: scoreboard pops on each write, pulse bookkeeping
  always @(negedge clk) begin
    if (cpu_rst) begin
      if (itcm_we) begin
        chk("we_while_hold", 32'(core_hold), 32'd1);
        if (exp_addr.size() == 0) begin
          chk("we_unexpected", 32'(itcm_we), 32'd0);
        end else begin
          chk("wr_addr", 32'(itcm_addr), 32'(exp_addr.pop_front()));
          chk("wr_data", itcm_wdata, exp_data.pop_front());
        end
      end
      if (load_done || load_error)
        chk("done_err_excl", 32'(load_done & load_error), 32'd0);
      if (prev_hold && !core_hold)
        chk("hold_drop_pulse", 32'(load_done | load_error), 32'd1);
      if (load_done) n_done++;
      if (load_error) n_err++;
    end
    prev_hold = core_hold;
  end

  initial begin
    #2 cpu_rst = 1'b0;
    idle(3);
    chk_outputs_zero("reset");
    cpu_rst = 1'b1;
    idle(5);

    // Two-word load; checksum 13+93+10 = B6
    d0 = n_done; e0 = n_err;
    expect_wr(12'h000, 32'h0000_0013);
    expect_wr(12'h004, 32'h0010_0093);
    send_vec(128'({8'hA5}), 1);
    chk("a_hold_after_sync", 32'(core_hold), 32'd1);
    send_vec(128'({8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00}), 10);
    chk("a_hold_before_cs", 32'(core_hold), 32'd1);
    send_vec(128'({8'hB6}), 1);
    idle(10);
    chk("a_done", 32'(n_done - d0), 32'd1);
    chk("a_err", 32'(n_err - e0), 32'd0);
    chk("a_hold_end", 32'(core_hold), 32'd0);
    chk("a_wq_empty", 32'(exp_addr.size()), 32'd0);

    // Same frame, wrong checksum: writes happen, then abort
    d0 = n_done; e0 = n_err;
    expect_wr(12'h000, 32'h0000_0013);
    expect_wr(12'h004, 32'h0010_0093);
    send_vec(128'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h37}), 12);
    idle(10);
    chk("b_done", 32'(n_done - d0), 32'd0);
    chk("b_err", 32'(n_err - e0), 32'd1);
    chk("b_hold_end", 32'(core_hold), 32'd0);
    chk("b_wq_empty", 32'(exp_addr.size()), 32'd0);

    // Noise byte ignored, then inter-byte timeout
    d0 = n_done; e0 = n_err;
    send_vec(128'({8'h55}), 1);
    chk("c_hold_after_noise", 32'(core_hold), 32'd0);
    send_vec(128'({8'hA5, 8'h01, 8'h00}), 3);
    chk("c_hold_in_frame", 32'(core_hold), 32'd1);
    idle(1500);
    chk("c_no_early_timeout", 32'(n_err - e0), 32'd0);
    idle(600);
    chk("c_err", 32'(n_err - e0), 32'd1);
    chk("c_done", 32'(n_done - d0), 32'd0);
    chk("c_hold_end", 32'(core_hold), 32'd0);

    // Word count 1025 exceeds capacity
    d0 = n_done; e0 = n_err;
    send_vec(128'({8'hA5, 8'h01, 8'h04}), 3);
    idle(5);
    chk("d_err", 32'(n_err - e0), 32'd1);
    chk("d_hold_end", 32'(core_hold), 32'd0);

    // Framing error on 2nd data byte, then a good 1-word frame (sum EF+BE+AD+DE = 38)
    d0 = n_done; e0 = n_err;
    send_vec(128'({8'hA5, 8'h01, 8'h00, 8'h11}), 4);
    send_byte(8'h22, 1'b0);
    idle(5);
    chk("e_err", 32'(n_err - e0), 32'd1);
    chk("e_hold_end", 32'(core_hold), 32'd0);
    d0 = n_done; e0 = n_err;
    expect_wr(12'h000, 32'hDEAD_BEEF);
    send_vec(128'({8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38}), 8);
    idle(10);
    chk("e_done", 32'(n_done - d0), 32'd1);
    chk("e_err2", 32'(n_err - e0), 32'd0);
    chk("e_wq_empty", 32'(exp_addr.size()), 32'd0);

    // Reset in the middle of DATA, then a fresh load starts at address 0
    expect_wr(12'h000, 32'h0000_0013);
    send_vec(128'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93}), 8);
    idle(3);
    chk("f_first_word", 32'(exp_addr.size()), 32'd0);
    chk("f_hold_mid", 32'(core_hold), 32'd1);
    @(negedge clk);
    cpu_rst = 1'b0;
    #1;
    chk_outputs_zero("f_rst");
    idle(3);
    cpu_rst = 1'b1;
    idle(5);
    d0 = n_done; e0 = n_err;
    expect_wr(12'h000, 32'h1234_5678);
    send_vec(128'({8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14}), 8);
    idle(10);
    chk("f_done", 32'(n_done - d0), 32'd1);
    chk("f_err", 32'(n_err - e0), 32'd0);
    chk("f_wq_empty", 32'(exp_addr.size()), 32'd0);
    chk("f_hold_end", 32'(core_hold), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
